frame_sequencer: RTL and testbench

Top-level frame controller that sits directly upstream of the screen-erase and sprite-draw stages and downstream of them toward the VGA adapter. Each frame it sequences erase → draw → game-state update → wait for frame tick, and issues one-cycle clear pulses so the stages' sticky done flags rearm. It also registers and multiplexes the erase and draw pixel streams onto a single VGA write port with a plot strobe.

---
 rtl/frame_sequencer_if.sv | 26 ++
 rtl/frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_frame_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Pixel bus between the erase/draw stages and the VGA adapter, routed through the sequencer.
interface frame_sequencer_if;
    logic [7:0] erase_x;
    logic [6:0] erase_y;
    logic [2:0] erase_colour;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] draw_colour;
    logic       draw_plot;
    logic [7:0] VGA_x;
    logic [6:0] VGA_y;
    logic [2:0] VGA_Colour;
    logic       VGA_plot;

    modport master (
        output erase_x, erase_y, erase_colour,
        output draw_x, draw_y, draw_colour, draw_plot,
        input  VGA_x, VGA_y, VGA_Colour, VGA_plot
    );

    modport slave (
        input  erase_x, erase_y, erase_colour,
        input  draw_x, draw_y, draw_colour, draw_plot,
        output VGA_x, VGA_y, VGA_Colour, VGA_plot
    );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame controller: erase -> draw -> update -> wait for frame tick, with a
// registered erase/draw pixel mux onto the VGA write port.
module frame_sequencer #(
    parameter int unsigned FRAME_TICKS = 833333,
    parameter int unsigned FT_W        = 20,
    parameter int unsigned TIMEOUT     = 1000000,
    parameter int unsigned TO_W        = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    space_pressed,
    input  logic                    game_over,
    input  logic                    doneErase,
    input  logic                    doneDraw,
    frame_sequencer_if.slave        pix,
    output logic                    EraseState,
    output logic                    DrawState,
    output logic                    sub_clear,
    output logic                    update_en,
    output logic                    timeout_err,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR_E = 3'd1,
        ERASE   = 3'd2,
        CLEAR_D = 3'd3,
        DRAW    = 3'd4,
        UPDATE  = 3'd5,
        WAIT    = 3'd6,
        OVER    = 3'd7
    } state_t;

    localparam logic [FT_W-1:0] FT_LAST = FT_W'(FRAME_TICKS - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [FT_W-1:0] frame_q, frame_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            terr_q, terr_d;
    logic            tick;
    logic [7:0]      vx_q;
    logic [6:0]      vy_q;
    logic [2:0]      vc_q;
    logic            vplot_q;

    assign tick = (frame_q == FT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            to_q    <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            to_q    <= to_d;
            terr_q  <= terr_d;
        end
    end

    // Every entry into ERASE/DRAW passes through a non-counting state, so
    // to_q == 0 marks the first cycle in the stage (done is ignored there).
    always_comb begin
        state_d = state_q;
        terr_d  = terr_q;
        frame_d = tick ? '0 : frame_q + 1'b1;
        to_d    = (state_q == ERASE || state_q == DRAW) ? to_q + 1'b1 : '0;
        if (space_pressed) begin
            state_d = CLEAR_E;
            terr_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                CLEAR_E: state_d = ERASE;
                ERASE: begin
                    if (to_q == TO_LAST) begin
                        state_d = IDLE;
                        terr_d  = 1'b1;
                    end else if (doneErase && to_q != '0) begin
                        state_d = CLEAR_D;
                    end
                end
                CLEAR_D: state_d = DRAW;
                DRAW: begin
                    if (to_q == TO_LAST) begin
                        state_d = IDLE;
                        terr_d  = 1'b1;
                    end else if (doneDraw && to_q != '0) begin
                        state_d = UPDATE;
                    end
                end
                UPDATE:  state_d = game_over ? OVER : WAIT;
                WAIT:    state_d = tick ? CLEAR_E : WAIT;
                OVER:    state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        EraseState = 1'b0;
        DrawState  = 1'b0;
        sub_clear  = 1'b0;
        update_en  = 1'b0;
        case (state_q)
            CLEAR_E, CLEAR_D: sub_clear  = 1'b1;
            ERASE:            EraseState = 1'b1;
            DRAW:             DrawState  = 1'b1;
            UPDATE:           update_en  = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
            vplot_q <= 1'b0;
        end else begin
            case (state_q)
                ERASE: begin
                    vx_q    <= pix.erase_x;
                    vy_q    <= pix.erase_y;
                    vc_q    <= pix.erase_colour;
                    vplot_q <= 1'b1;
                end
                DRAW: begin
                    vx_q    <= pix.draw_x;
                    vy_q    <= pix.draw_y;
                    vc_q    <= pix.draw_colour;
                    vplot_q <= pix.draw_plot;
                end
                default: vplot_q <= 1'b0;
            endcase
        end
    end

    assign pix.VGA_x      = vx_q;
    assign pix.VGA_y      = vy_q;
    assign pix.VGA_Colour = vc_q;
    assign pix.VGA_plot   = vplot_q;
    assign timeout_err    = terr_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected state/strobes/pixels queued per step.
module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       space_pressed, game_over, doneErase, doneDraw;
    logic       EraseState, DrawState, sub_clear, update_en, timeout_err;
    logic [2:0] state_dbg;

    frame_sequencer_if pix ();

    frame_sequencer #(
        .FRAME_TICKS (16),
        .FT_W        (5),
        .TIMEOUT     (32),
        .TO_W        (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .space_pressed (space_pressed),
        .game_over     (game_over),
        .doneErase     (doneErase),
        .doneDraw      (doneDraw),
        .pix           (pix.slave),
        .EraseState    (EraseState),
        .DrawState     (DrawState),
        .sub_clear     (sub_clear),
        .update_en     (update_en),
        .timeout_err   (timeout_err),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    // Independent frame-period counter: value during the current cycle.
    int unsigned fc_m;
    always @(posedge clk or negedge reset) begin
        if (!reset) fc_m <= 0;
        else        fc_m <= (fc_m == 15) ? 0 : fc_m + 1;
    end

    typedef struct {
        logic [2:0] st;
        logic       terr;
        logic       chk_pix;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [2:0] lc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check("state_dbg",   32'(state_dbg),   32'(e.st));
        check("sub_clear",   32'(sub_clear),   32'(e.st == 3'd1 || e.st == 3'd3));
        check("EraseState",  32'(EraseState),  32'(e.st == 3'd2));
        check("DrawState",   32'(DrawState),   32'(e.st == 3'd4));
        check("update_en",   32'(update_en),   32'(e.st == 3'd5));
        check("timeout_err", 32'(timeout_err), 32'(e.terr));
        if (e.chk_pix) begin
            check("VGA_plot",   32'(pix.VGA_plot),   32'(e.plot));
            check("VGA_x",      32'(pix.VGA_x),      32'(e.x));
            check("VGA_y",      32'(pix.VGA_y),      32'(e.y));
            check("VGA_Colour", 32'(pix.VGA_Colour), 32'(e.c));
        end
    endtask

    task automatic step(input logic [2:0] st, input logic terr);
        exp_t e;
        e = '{st: st, terr: terr, chk_pix: 1'b0, plot: 1'b0, x: '0, y: '0, c: '0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic step_pix(input logic [2:0] st, input logic terr, input logic plot,
                            input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        exp_t e;
        e = '{st: st, terr: terr, chk_pix: 1'b1, plot: plot, x: x, y: y, c: c};
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic expect_now(input logic [2:0] st, input logic terr);
        exp_t e;
        e = '{st: st, terr: terr, chk_pix: 1'b1, plot: 1'b0, x: '0, y: '0, c: '0};
        sb.push_back(e);
        compare_front();
    endtask

    initial begin
        int budget;
        reset = 1'b0;
        space_pressed = 1'b0; game_over = 1'b0; doneErase = 1'b0; doneDraw = 1'b0;
        pix.erase_x = '0; pix.erase_y = '0; pix.erase_colour = '0;
        pix.draw_x = '0; pix.draw_y = '0; pix.draw_colour = '0; pix.draw_plot = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_now(3'd0, 1'b0);
        reset = 1'b1;
        step(3'd0, 1'b0);

        // Normal frame; doneErase held high across CLEAR_E into the first ERASE cycle
        space_pressed = 1'b1;
        step(3'd1, 1'b0);
        space_pressed = 1'b0;
        doneErase = 1'b1;
        pix.erase_x = 8'd5; pix.erase_y = 7'd6; pix.erase_colour = 3'd7;
        step_pix(3'd2, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        step_pix(3'd2, 1'b0, 1'b1, 8'd5, 7'd6, 3'd7);
        doneErase = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pix.erase_x = 8'(10 + i); pix.erase_y = 7'(i); pix.erase_colour = 3'(i);
            step_pix(3'd2, 1'b0, 1'b1, 8'(10 + i), 7'(i), 3'(i));
        end
        doneErase = 1'b1;
        pix.erase_x = 8'd20; pix.erase_y = 7'd21; pix.erase_colour = 3'd2;
        step_pix(3'd3, 1'b0, 1'b1, 8'd20, 7'd21, 3'd2);
        doneErase = 1'b0;
        doneDraw = 1'b1;
        pix.draw_x = 8'd42; pix.draw_y = 7'd17; pix.draw_colour = 3'b100; pix.draw_plot = 1'b1;
        step_pix(3'd4, 1'b0, 1'b0, 8'd20, 7'd21, 3'd2);
        step_pix(3'd4, 1'b0, 1'b1, 8'd42, 7'd17, 3'b100);
        doneDraw = 1'b0;
        pix.draw_x = 8'd99; pix.draw_y = 7'd1; pix.draw_colour = 3'd2; pix.draw_plot = 1'b0;
        step_pix(3'd4, 1'b0, 1'b0, 8'd99, 7'd1, 3'd2);
        doneDraw = 1'b1;
        pix.draw_x = 8'd7; pix.draw_y = 7'd8; pix.draw_colour = 3'd3; pix.draw_plot = 1'b1;
        step_pix(3'd5, 1'b0, 1'b1, 8'd7, 7'd8, 3'd3);
        doneDraw = 1'b0;
        lx = 8'd7; ly = 7'd8; lc = 3'd3;
        step_pix(3'd6, 1'b0, 1'b0, lx, ly, lc);
        budget = 0;
        while (fc_m != 15 && budget < 20) begin
            step_pix(3'd6, 1'b0, 1'b0, lx, ly, lc);
            budget++;
        end
        check("tick_bound", 32'(budget < 20), 32'd1);
        step(3'd1, 1'b0);

        // Timeout: doneErase never rises
        step(3'd2, 1'b0);
        for (int k = 1; k < 32; k++) step(3'd2, 1'b0);
        step(3'd0, 1'b1);
        step(3'd0, 1'b1);
        space_pressed = 1'b1;
        step(3'd1, 1'b0);
        space_pressed = 1'b0;

        // Game over
        step(3'd2, 1'b0);
        doneErase = 1'b1;
        step(3'd2, 1'b0);
        step(3'd3, 1'b0);
        doneErase = 1'b0;
        step(3'd4, 1'b0);
        doneDraw = 1'b1;
        step(3'd4, 1'b0);
        step(3'd5, 1'b0);
        doneDraw = 1'b0;
        game_over = 1'b1;
        step(3'd7, 1'b0);
        repeat (4) step(3'd7, 1'b0);
        space_pressed = 1'b1;
        step(3'd1, 1'b0);
        space_pressed = 1'b0;
        game_over = 1'b0;

        // Async reset between edges while in ERASE
        pix.erase_x = 8'd3; pix.erase_y = 7'd3; pix.erase_colour = 3'd3;
        step(3'd2, 1'b0);
        step_pix(3'd2, 1'b0, 1'b1, 8'd3, 7'd3, 3'd3);
        #2;
        reset = 1'b0;
        #1;
        expect_now(3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
